// File: rtl/pack_out_reg.sv
// Output register slice for the word packer.
// Holds one packed word with its count and last flag until accepted.
module pack_out_reg #(
  parameter int DW = 64,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic [CW-1:0] count_i,
  input  logic          last_i,
  input  logic          ready_i,
  output logic          free_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [CW-1:0] count_o,
  output logic          last_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_q, last_d;

  assign free_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      count_d = count_i;
      last_d  = last_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign count_o = count_q;
  assign last_o  = last_q;

endmodule

// File: rtl/buffer_pack.sv
// Serial-to-parallel packer: groups NUM input words into one wide word.
// Newest word lands in slot 0; a group may close early on s_last.
module buffer_pack #(
  parameter int NUM   = 4,
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [WIDTH-1:0]        s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [NUM*WIDTH-1:0]    m_data,
  output logic [$clog2(NUM+1)-1:0] m_count,
  output logic                    m_last
);

  localparam int DW = NUM * WIDTH;
  localparam int CW = $clog2(NUM + 1);

  logic [DW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          last_q, last_d;

  logic          out_free;
  logic          xfer;
  logic          fire;
  logic [DW-1:0] acc_base;
  logic [DW-1:0] acc_shift;
  logic [CW-1:0] cnt_base;
  logic [CW-1:0] cnt_inc;

  assign s_ready = !done_q || out_free;
  assign fire    = s_valid && s_ready;
  assign xfer    = done_q && out_free;

  // A transfer empties acc in the same cycle a new beat may land in it.
  assign acc_base = xfer ? '0 : acc_q;
  assign cnt_base = xfer ? '0 : cnt_q;
  assign cnt_inc  = cnt_base + CW'(1);

  if (NUM == 1) begin : g_one
    assign acc_shift = s_data;
  end else begin : g_many
    assign acc_shift = {acc_base[(NUM-1)*WIDTH-1:0], s_data};
  end

  always_comb begin
    acc_d  = acc_base;
    cnt_d  = cnt_base;
    done_d = done_q && !xfer;
    last_d = xfer ? 1'b0 : last_q;
    if (fire) begin
      acc_d  = acc_shift;
      cnt_d  = cnt_inc;
      done_d = (cnt_inc == CW'(NUM)) || s_last;
      last_d = s_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      last_q <= last_d;
    end
  end

  pack_out_reg #(
    .DW (DW),
    .CW (CW)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .load_i  (xfer),
    .data_i  (acc_q),
    .count_i (cnt_q),
    .last_i  (last_q),
    .ready_i (m_ready),
    .free_o  (out_free),
    .valid_o (m_valid),
    .data_o  (m_data),
    .count_o (m_count),
    .last_o  (m_last)
  );

endmodule

// File: tb/tb_buffer_pack.sv
// Scoreboard bench for buffer_pack (NUM=4, WIDTH=16).
// Reference groups words in a queue; monitor compares each packed word.
module tb_buffer_pack;

  localparam int NUM   = 4;
  localparam int WIDTH = 16;
  localparam int DW    = NUM * WIDTH;
  localparam int CW    = $clog2(NUM + 1);

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          l;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [DW-1:0]    m_data;
  logic [CW-1:0]    m_count;
  logic             m_last;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int n_out = 0;

  logic [WIDTH-1:0] grp[$];
  exp_t             expq[$];
  int               fire_cyc[$];

  logic          stall_prev = 1'b0;
  logic [DW-1:0] d_prev;
  logic [CW-1:0] c_prev;
  logic          l_prev;

  buffer_pack #(.NUM(NUM), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_count (m_count),
    .m_last  (m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t pack(input int n, input logic [WIDTH-1:0] w[$],
                                input logic l);
    exp_t e;
    e.d = '0;
    for (int i = 0; i < n; i++)
      e.d = e.d | (DW'(w[i]) << (WIDTH * (n - 1 - i)));
    e.c = CW'(n);
    e.l = l;
    return e;
  endfunction

  // Monitor/scoreboard: handshakes seen here complete on the next edge.
  always @(negedge clk) begin
    if (rst) begin
      grp.delete();
      expq.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", DW'(m_valid), DW'(1));
        chk("hold_data", m_data, d_prev);
        chk("hold_count", DW'(m_count), DW'(c_prev));
        chk("hold_last", DW'(m_last), DW'(l_prev));
      end
      if (m_valid && m_ready) begin
        n_out++;
        fire_cyc.push_back(cyc);
        if (expq.size() == 0) begin
          chk("unexpected_output", DW'(1), DW'(0));
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("m_data", m_data, e.d);
          chk("m_count", DW'(m_count), DW'(e.c));
          chk("m_last", DW'(m_last), DW'(e.l));
        end
      end
      if (s_valid && s_ready) begin
        grp.push_back(s_data);
        if (grp.size() == NUM || s_last) begin
          expq.push_back(pack(grp.size(), grp, s_last));
          grp.delete();
        end
      end
      stall_prev = m_valid && !m_ready;
      d_prev = m_data;
      c_prev = m_count;
      l_prev = m_last;
    end
  end

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send(input logic [WIDTH-1:0] d, input logic l);
    logic ok;
    int   n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("send_timeout", DW'(0), DW'(1));
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_m_valid", DW'(m_valid), DW'(0));
    chk("rst_m_data", m_data, '0);
    chk("rst_m_count", DW'(m_count), DW'(0));
    chk("rst_m_last", DW'(m_last), DW'(0));
    chk("rst_s_ready", DW'(s_ready), DW'(1));
    @(posedge clk);
    #1;

    // Full group and its latency
    m_ready = 1'b1;
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    send(16'h3333, 1'b0);
    send(16'h4444, 1'b0);
    s_valid = 1'b0;
    @(negedge clk);
    chk("lat_t0", DW'(m_valid), DW'(0));
    @(negedge clk);
    chk("lat_t1", DW'(m_valid), DW'(1));
    chk("full_data", m_data, 64'h1111_2222_3333_4444);
    @(negedge clk);
    chk("lat_t2", DW'(m_valid), DW'(0));
    idle(2);

    // Partial flush
    send(16'hAAAA, 1'b0);
    send(16'hBBBB, 1'b1);
    idle(4);

    // Backpressure
    m_ready = 1'b0;
    base = n_out;
    for (int i = 1; i <= 8; i++) send(WIDTH'(i), 1'b0);
    fork
      begin
        for (int i = 9; i <= 12; i++) send(WIDTH'(i), 1'b0);
        s_valid = 1'b0;
      end
      begin
        repeat (4) begin
          @(negedge clk);
          chk("bp_s_ready", DW'(s_ready), DW'(0));
          chk("bp_head", m_data, 64'h0001_0002_0003_0004);
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    idle(8);
    chk("bp_outputs", DW'(n_out - base), DW'(3));

    // Throughput
    fire_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1;
      s_data  = WIDTH'(16'h100 + i);
      s_last  = 1'b0;
      @(negedge clk);
      chk("tp_s_ready", DW'(s_ready), DW'(1));
      @(posedge clk);
      #1;
    end
    idle(6);
    chk("tp_count", DW'(fire_cyc.size()), DW'(4));
    for (int i = 1; i < fire_cyc.size(); i++)
      chk("tp_spacing", DW'(fire_cyc[i] - fire_cyc[i-1]), DW'(4));

    // Reset mid-group
    send(16'h00E1, 1'b0);
    send(16'h00E2, 1'b0);
    send(16'h00E3, 1'b0);
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst2_s_ready", DW'(s_ready), DW'(1));
    chk("rst2_m_valid", DW'(m_valid), DW'(0));
    @(posedge clk);
    #1;
    base = n_out;
    fire_cyc.delete();
    for (int i = 5; i <= 8; i++) send(WIDTH'(i), 1'b0);
    idle(6);
    chk("rst2_outputs", DW'(n_out - base), DW'(1));

    // Randomized traffic with random backpressure
    begin
      logic acc_ok;
      s_valid = 1'b0;
      for (int i = 0; i < 600; i++) begin
        @(negedge clk);
        acc_ok = s_valid && s_ready;
        @(posedge clk);
        #1;
        m_ready = ($urandom_range(0, 3) != 0);
        if (!s_valid || acc_ok) begin
          s_valid = ($urandom_range(0, 3) != 0);
          s_data  = WIDTH'($urandom);
          s_last  = ($urandom_range(0, 4) == 0);
        end
      end
      if (s_valid) begin
        @(negedge clk);
        acc_ok = s_ready;
        @(posedge clk);
        #1;
        if (!acc_ok) send(s_data, s_last);
      end
      m_ready = 1'b1;
      send(WIDTH'($urandom), 1'b1);
      idle(8);
    end
    chk("drain_expq", DW'(expq.size()), DW'(0));
    chk("drain_grp", DW'(grp.size()), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
